// File: rtl/a0_trace_fifo.sv
// Timestamped change log of the CPU a0 register: each new a0 value is paired with
// the free-running cycle count and queued in a first-word-fall-through FIFO.
module a0_trace_fifo #(
   parameter int DEPTH    = 16,
   parameter int TS_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en_i,
   input  logic [31:0]               a0_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [31:0]               value_o,
   output logic [TS_WIDTH-1:0]       stamp_o,
   output logic [$clog2(DEPTH):0]    count_o,
   output logic                      overflow_o,
   input  logic                      clr_ovf_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [31:0]         value;
      logic [TS_WIDTH-1:0] stamp;
   } entry_t;

   entry_t              mem_q [DEPTH];
   entry_t              head;
   logic [TS_WIDTH-1:0] cnt_q, cnt_d;
   logic [31:0]         last_q, last_d;
   logic                primed_q, primed_d;
   logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                det, push, pop, drop;

   always_comb begin
      det  = en_i && (!primed_q || (a0_i != last_q));
      pop  = (count_q != '0) && ready_i;
      // A full FIFO still takes the new entry when the head leaves on the same edge.
      push = det && ((count_q != FULL) || pop);
      drop = det && !push;

      cnt_d    = cnt_q + TS_WIDTH'(1);
      last_d   = det ? a0_i : last_q;
      primed_d = primed_q | det;
      wptr_d   = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d   = pop  ? rptr_q + AW'(1) : rptr_q;

      count_d = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);

      ovf_d = ovf_q;
      if (drop)           ovf_d = 1'b1;
      else if (clr_ovf_i) ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         last_q   <= '0;
         primed_q <= 1'b0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         primed_q <= primed_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= '{value: a0_i, stamp: cnt_q};
   end

   always_comb begin
      head       = mem_q[rptr_q];
      valid_o    = (count_q != '0);
      value_o    = valid_o ? head.value : '0;
      stamp_o    = valid_o ? head.stamp : '0;
      count_o    = count_q;
      overflow_o = ovf_q;
   end

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Directed plus randomized bench for a0_trace_fifo, compared cycle by cycle
// against a queue-based model of the change log.
module tb_a0_trace_fifo;

   localparam int DEPTH = 16;
   localparam int TSW   = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            en_i, ready_i, clr_ovf_i;
   logic [31:0]     a0_i;
   logic            valid_o, overflow_o;
   logic [31:0]     value_o;
   logic [TSW-1:0]  stamp_o;
   logic [4:0]      count_o;

   a0_trace_fifo #(.DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
      .clk(clk), .rst(rst), .en_i(en_i), .a0_i(a0_i), .valid_o(valid_o),
      .ready_i(ready_i), .value_o(value_o), .stamp_o(stamp_o), .count_o(count_o),
      .overflow_o(overflow_o), .clr_ovf_i(clr_ovf_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]    v;
      logic [TSW-1:0] s;
   } ent_t;

   ent_t           q[$];
   logic [TSW-1:0] m_cnt;
   logic [31:0]    m_last;
   logic           m_primed, m_ovf;
   int             passed = 0, total = 0, failed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_cnt = '0; m_last = '0; m_primed = 1'b0; m_ovf = 1'b0;
   endtask

   // One clock cycle: drive, compare the visible head state, advance the model.
   task automatic step(input logic en, input logic [31:0] a0, input logic rdy, input logic clr);
      bit det, pop, push;
      en_i = en; a0_i = a0; ready_i = rdy; clr_ovf_i = clr;
      #1;
      check("valid", 32'(valid_o), 32'(q.size() != 0));
      check("value", value_o, (q.size() != 0) ? q[0].v : 32'd0);
      check("stamp", 32'(stamp_o), (q.size() != 0) ? 32'(q[0].s) : 32'd0);
      check("count", 32'(count_o), 32'(q.size()));
      check("overflow", 32'(overflow_o), 32'(m_ovf));
      det  = en && (!m_primed || a0 != m_last);
      pop  = (q.size() != 0) && rdy;
      push = det && (q.size() < DEPTH || pop);
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{v: a0, s: m_cnt});
      if (det) begin m_last = a0; m_primed = 1'b1; end
      if (det && !push) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_cnt = m_cnt + 1'b1;
      @(negedge clk);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      rst = 1'b0; en_i = 1'b0; a0_i = '0; ready_i = 1'b0; clr_ovf_i = 1'b0;
      model_reset();
      #1;
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_count", 32'(count_o), 32'd0);
      check("rst_value", value_o, 32'd0);
      check("rst_ovf", 32'(overflow_o), 32'd0);
      release_reset();

      // a0 held at 0 logs a single entry; drain it at cycle 9
      for (int i = 0; i < 9; i++) step(1, 32'd0, 0, 0);
      step(1, 32'd0, 1, 0);
      check("init_entries", 32'(q.size()), 32'd0);
      begin
         int seq[6] = '{5, 5, 7, 7, 7, 9};
         foreach (seq[i]) step(1, 32'(seq[i]), 1, 0);
      end
      step(1, 32'd9, 1, 0);
      step(1, 32'd9, 1, 0);

      // overflow: 20 changes with no consumer
      for (int i = 0; i < 20; i++) step(1, 32'(100 + i), 0, 0);
      check("ovf_set", 32'(overflow_o), 32'd1);
      check("ovf_full", 32'(count_o), 32'd16);
      step(0, 32'd0, 0, 1);
      check("ovf_clr", 32'(overflow_o), 32'd0);
      // full with simultaneous pop and push: no drop
      step(1, 32'd555, 1, 0);
      check("fullpop_ovf", 32'(overflow_o), 32'd0);
      check("fullpop_count", 32'(count_o), 32'd16);
      for (int i = 0; i < 18; i++) step(0, 32'd555, 1, 0);

      // disabled capture, then re-enable with the value already changed
      step(0, 32'd3, 0, 0);
      step(0, 32'd4, 0, 0);
      step(1, 32'd4, 0, 0);
      step(1, 32'd4, 0, 0);
      check("reenable_one", 32'(count_o), 32'd1);
      step(0, 32'd4, 1, 0);
      step(0, 32'd4, 1, 0);

      // stamp wrap: changes at cycles 254 and 257
      while (m_cnt != 8'd254) step(0, 32'd4, 1, 0);
      step(1, 32'h11, 0, 0);
      step(1, 32'h11, 0, 0);
      step(1, 32'h11, 0, 0);
      step(1, 32'h22, 0, 0);
      check("wrap_s0", 32'(stamp_o), 32'd254);
      step(1, 32'h22, 1, 0);
      check("wrap_s1", 32'(stamp_o), 32'd1);
      step(1, 32'h22, 1, 0);

      // random traffic: slow consumer, then fast consumer
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 3) != 0, 32'($urandom_range(0, 3)),
              $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 3) != 0, 32'($urandom_range(0, 5)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);

      // queue five entries, then reset asynchronously mid-cycle
      while (q.size() != 0) step(0, 32'd0, 1, 1);
      for (int i = 0; i < 5; i++) step(1, 32'(200 + i), 0, 0);
      check("pre_rst_count", 32'(count_o), 32'd5);
      #2 rst = 1'b0;
      #1;
      check("arst_valid", 32'(valid_o), 32'd0);
      check("arst_value", value_o, 32'd0);
      check("arst_stamp", 32'(stamp_o), 32'd0);
      check("arst_count", 32'(count_o), 32'd0);
      release_reset();
      step(1, 32'd204, 0, 0);
      step(1, 32'd204, 1, 0);
      step(1, 32'd204, 1, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/a0_trace_fifo.md
# a0_trace_fifo

Observation stage that sits directly downstream of the CPU's `a0` output. It timestamps every change of `a0` against a free-running cycle counter and buffers each (value, stamp) pair in a first-word-fall-through FIFO. A testbench, display driver or debug link drains the FIFO over a valid/ready handshake, so intermittent `a0` activity is never lost to a slow consumer unless the FIFO overflows.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥ 2.
- `TS_WIDTH`, 32: width of the cycle counter and stamp.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en_i`  in  1  capture enable.
- `a0_i`  in  32  CPU `a0` register value.
- `valid_o`  out  1  head entry available.
- `ready_i`  in  1  consumer accepts head entry.
- `value_o`  out  32  head entry `a0` value.
- `stamp_o`  out  TS_WIDTH  head entry cycle stamp.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow_o`  out  1  sticky: at least one entry was dropped.
- `clr_ovf_i`  in  1  clears `overflow_o`.

## Operation
- Cycle counter `cnt`:
  - Resets to 0.
  - Increments by 1 every cycle, regardless of `en_i`.
  - Wraps modulo 2^TS_WIDTH with no flag.
- Change detect:
  - `det = en_i && (!primed || a0_i != last)`.
  - `primed` and `last` reset to 0.
- On `det`:
  - `last <= a0_i` and `primed <= 1`.
  - Both update even when the entry is dropped, so a dropped value is not re-logged while it stays unchanged.
- `en_i` low: no detection; `last` and `primed` hold.
- Push: on `det`, write {`a0_i`, `cnt`} at the tail.
  - Accepted when `count < DEPTH`.
  - Also accepted when `count == DEPTH` and a pop occurs in the same cycle.
- Pop: `valid_o && ready_i` advances the head.
- Occupancy on the same edge:
  - Push and pop together: `count` unchanged.
  - Push only: +1.
  - Pop only: −1.
- Drop: `det` while `count == DEPTH` with no pop. The entry is discarded and `overflow_o <= 1`.
- `clr_ovf_i` clears `overflow_o` on the next edge. If a drop occurs in the same cycle, set wins.
- `valid_o = (count_o != 0)`.
- `value_o` and `stamp_o` show the head entry combinationally (FWFT) and are forced to 0 when `valid_o` is low.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are distinguished by `count`, not by pointer equality.
- Holding `ready_i` high with `valid_o` low has no effect.

## Timing
- Reset (`rst` low, asynchronous):
  - `valid_o`=0, `value_o`=0, `stamp_o`=0, `count_o`=0, `overflow_o`=0.
  - `cnt`=0, `primed`=0, `last`=0.
  - FIFO contents are don't-care.
- Reset deasserted mid-operation: all queued entries are lost. The first enabled cycle after release always logs the current `a0_i`.
- Capture latency:
  - A change visible on `a0_i` in cycle N is stamped with the `cnt` value of cycle N.
  - If the FIFO was empty, `valid_o` rises in cycle N+1.
- No bypass: an entry pushed into an empty FIFO cannot be popped in the same cycle.
- Pop is consumed on the edge ending a cycle with `valid_o && ready_i`. The next entry, or `valid_o`=0, is visible in the following cycle.
- Throughput: one push and one pop per cycle sustained.
- `a0_i` is sampled only at the rising edge of `clk`. Glitches between edges are ignored.

## Test plan
- Reset, `en_i`=1, `a0_i`=0 held, `ready_i`=0:
  - One entry {value 0, stamp 0}.
  - `count_o`=1, `valid_o` high from cycle 1.
  - No further entries.
- `a0_i` sequence 5,5,7,7,7,9 starting at cycle 10 (after the initial 0 entry was drained), `ready_i`=1:
  - Entries {5,10}, {7,12}, {9,15}, each appearing on `valid_o` one cycle after its change.
- `ready_i`=0, `DEPTH`=16, `a0_i` changes every cycle for 20 cycles:
  - `count_o` saturates at 16.
  - `overflow_o`=1 from the 17th change onward.
  - Drained entries are the first 16 values in order.
  - `clr_ovf_i` pulse with no drops → `overflow_o`=0.
- FIFO full, `ready_i`=1 and a change in the same cycle:
  - No drop, `count_o` stays 16, `overflow_o` stays 0.
  - Head advances and the new entry lands at the tail.
- `en_i`=0 while `a0_i` goes 3→4, then `en_i`=1 with `a0_i`=4:
  - Exactly one entry {4, stamp of the re-enable cycle}.
- Force `cnt` near 2^TS_WIDTH−1 (`TS_WIDTH`=8, change at cycles 254 and 257):
  - Stamps 254 then 1.
- Assert `rst` while 5 entries are queued:
  - Outputs zero immediately, without waiting for a clock edge.
